// File: rtl/ibex_pmp_csr_pkg.sv
// Shared PMP configuration types and constants used by the CSR bank and the checker.
package ibex_pmp_csr_pkg;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    localparam int PMP_CFG_LOCK_BIT = 7;
    localparam int PMP_CFG_MODE_LSB = 3;
    localparam int PMP_ADDR_W       = 34;

    localparam pmp_cfg_t PMP_CFG_RESET = '{
        lock:  1'b0,
        mode:  PMP_MODE_OFF,
        exec:  1'b0,
        write: 1'b0,
        read:  1'b0
    };

    // Architectural byte view of a stored config; reserved bits [6:5] read as zero.
    function automatic logic [7:0] pmp_cfg_to_byte(input pmp_cfg_t cfg);
        return {cfg.lock, 2'b00, cfg.mode, cfg.exec, cfg.write, cfg.read};
    endfunction

endpackage

// File: rtl/ibex_pmp_csr_legalize.sv
// WARL mapping of a pmpcfg write byte to a legal config, and granularity-dependent
// masking of the pmpaddr read view.
module ibex_pmp_csr_legalize
    import ibex_pmp_csr_pkg::*;
#(
    parameter int PMPGranularity = 0
) (
    input  logic [7:0]    cfg_wdata,
    output pmp_cfg_t      cfg_legal,
    input  pmp_cfg_mode_e rd_mode,
    input  logic [31:0]   rd_addr_stored,
    output logic [31:0]   rd_addr_masked
);

    // Low address bits forced to one (NAPOT) or zero (OFF/TOR) on readback.
    localparam logic [31:0] NAPOT_ONES =
        (32'd1 << ((PMPGranularity >= 2) ? (PMPGranularity - 1) : 0)) - 32'd1;
    localparam logic [31:0] ZERO_MASK = (32'd1 << PMPGranularity) - 32'd1;

    pmp_cfg_mode_e wmode;

    always_comb begin
        wmode = pmp_cfg_mode_e'(cfg_wdata[PMP_CFG_MODE_LSB +: 2]);

        cfg_legal       = PMP_CFG_RESET;
        cfg_legal.lock  = cfg_wdata[PMP_CFG_LOCK_BIT];
        cfg_legal.mode  = ((PMPGranularity >= 1) && (wmode == PMP_MODE_NA4)) ? PMP_MODE_OFF : wmode;
        cfg_legal.exec  = cfg_wdata[2];
        cfg_legal.read  = cfg_wdata[0];
        // Write without read is reserved; drop the write permission.
        cfg_legal.write = cfg_wdata[1] & cfg_wdata[0];

        rd_addr_masked = rd_addr_stored;
        if ((PMPGranularity >= 2) && (rd_mode == PMP_MODE_NAPOT)) begin
            rd_addr_masked = rd_addr_stored | NAPOT_ONES;
        end else if ((PMPGranularity >= 1) &&
                     ((rd_mode == PMP_MODE_OFF) || (rd_mode == PMP_MODE_TOR))) begin
            rd_addr_masked = rd_addr_stored & ~ZERO_MASK;
        end
    end

endmodule

// File: rtl/ibex_pmp_csr.sv
// PMP cfg/addr register bank feeding the PMP checker, with lock and WARL enforcement.
// Optional macro IBEX_PMP_CSR_LOCK_ALERT_EN adds pmp_lock_alert_o for discarded writes.
module ibex_pmp_csr
    import ibex_pmp_csr_pkg::*;
#(
    parameter int PMPNumRegions  = 4,
    parameter int PMPGranularity = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  csr_req_i,
    output logic                  csr_gnt_o,
    input  logic                  csr_we_i,
    input  logic                  csr_sel_addr_i,
    input  logic [3:0]            csr_idx_i,
    input  logic [31:0]           csr_wdata_i,
    output logic                  csr_rvalid_o,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_err_o,
`ifdef IBEX_PMP_CSR_LOCK_ALERT_EN
    output logic                  pmp_lock_alert_o,
`endif
    output pmp_cfg_t              csr_pmp_cfg_o  [PMPNumRegions],
    output logic [PMP_ADDR_W-1:0] csr_pmp_addr_o [PMPNumRegions]
);

    pmp_cfg_t    cfg_reg  [PMPNumRegions];
    logic [31:0] addr_reg [PMPNumRegions];

    logic        req_accept;
    logic        idx_valid;
    logic [PMPNumRegions-1:0] region_sel;
    logic [PMPNumRegions-1:0] cfg_locked;
    logic [PMPNumRegions-1:0] addr_locked;
    logic [PMPNumRegions-1:0] cfg_wr_en;
    logic [PMPNumRegions-1:0] addr_wr_en;

    pmp_cfg_t    cfg_legal;
    pmp_cfg_t    sel_cfg;
    logic [31:0] sel_addr;
    logic [31:0] sel_addr_masked;

    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic [31:0] rdata_next;
    logic        err_reg;

    assign csr_gnt_o  = ~rst_i;
    assign req_accept = csr_req_i & csr_gnt_o;
    assign idx_valid  = (32'(csr_idx_i) < PMPNumRegions);

    for (genvar gi = 0; gi < PMPNumRegions; gi++) begin : g_region
        assign region_sel[gi] = req_accept && (csr_idx_i == 4'(gi));
        assign cfg_locked[gi] = cfg_reg[gi].lock;

        // A locked TOR region above also freezes this region's address (its base).
        if (gi + 1 < PMPNumRegions) begin : g_tor_guard
            assign addr_locked[gi] = cfg_reg[gi].lock |
                                     (cfg_reg[gi+1].lock && (cfg_reg[gi+1].mode == PMP_MODE_TOR));
        end else begin : g_top_region
            assign addr_locked[gi] = cfg_reg[gi].lock;
        end

        assign cfg_wr_en[gi]  = region_sel[gi] & csr_we_i & ~csr_sel_addr_i & ~cfg_locked[gi];
        assign addr_wr_en[gi] = region_sel[gi] & csr_we_i &  csr_sel_addr_i & ~addr_locked[gi];

        assign csr_pmp_cfg_o[gi]  = cfg_reg[gi];
        assign csr_pmp_addr_o[gi] = {addr_reg[gi], 2'b00};
    end

    always_comb begin
        sel_cfg  = PMP_CFG_RESET;
        sel_addr = 32'd0;
        for (int i = 0; i < PMPNumRegions; i++) begin
            if (csr_idx_i == 4'(i)) begin
                sel_cfg  = cfg_reg[i];
                sel_addr = addr_reg[i];
            end
        end
    end

    ibex_pmp_csr_legalize #(
        .PMPGranularity (PMPGranularity)
    ) u_legalize (
        .cfg_wdata      (csr_wdata_i[7:0]),
        .cfg_legal      (cfg_legal),
        .rd_mode        (sel_cfg.mode),
        .rd_addr_stored (sel_addr),
        .rd_addr_masked (sel_addr_masked)
    );

    always_comb begin
        rdata_next = 32'd0;
        if (!csr_we_i && idx_valid) begin
            rdata_next = csr_sel_addr_i ? sel_addr_masked : {24'd0, pmp_cfg_to_byte(sel_cfg)};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PMPNumRegions; i++) begin
                cfg_reg[i]  <= PMP_CFG_RESET;
                addr_reg[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < PMPNumRegions; i++) begin
                if (cfg_wr_en[i]) begin
                    cfg_reg[i] <= cfg_legal;
                end
                if (addr_wr_en[i]) begin
                    addr_reg[i] <= csr_wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= 32'd0;
            err_reg    <= 1'b0;
        end else begin
            rvalid_reg <= req_accept;
            rdata_reg  <= req_accept ? rdata_next : 32'd0;
            err_reg    <= req_accept & ~idx_valid;
        end
    end

    assign csr_rvalid_o = rvalid_reg;
    assign csr_rdata_o  = rdata_reg;
    assign csr_err_o    = err_reg;

`ifdef IBEX_PMP_CSR_LOCK_ALERT_EN
    logic write_discarded;
    logic alert_reg;

    assign write_discarded = |(region_sel & {PMPNumRegions{csr_we_i}} &
                               (csr_sel_addr_i ? addr_locked : cfg_locked));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alert_reg <= 1'b0;
        end else begin
            alert_reg <= write_discarded;
        end
    end

    assign pmp_lock_alert_o = alert_reg;
`endif

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Randomized bench for ibex_pmp_csr: three instances (G = 0, 1, 2) driven in lockstep
// and checked every cycle against a behavioural register-bank model.
`timescale 1ns/1ps
module tb_ibex_pmp_csr;
    import ibex_pmp_csr_pkg::*;

    localparam int N  = 4;
    localparam int NG = 3;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic        sel   = 1'b0;
    logic [3:0]  idx   = 4'd0;
    logic [31:0] wdata = 32'd0;

    logic [NG-1:0] gnt, rvalid, err;
    logic [31:0]   rdata [NG];
    pmp_cfg_t      pcfg  [NG][N];
    logic [33:0]   paddr [NG][N];
`ifdef IBEX_PMP_CSR_LOCK_ALERT_EN
    logic [NG-1:0] alert;
`endif

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NG; gi++) begin : g_dut
        ibex_pmp_csr #(
            .PMPNumRegions  (N),
            .PMPGranularity (gi)
        ) u_dut (
            .clk_i            (clk),
            .rst_i            (rst),
            .csr_req_i        (req),
            .csr_gnt_o        (gnt[gi]),
            .csr_we_i         (we),
            .csr_sel_addr_i   (sel),
            .csr_idx_i        (idx),
            .csr_wdata_i      (wdata),
            .csr_rvalid_o     (rvalid[gi]),
            .csr_rdata_o      (rdata[gi]),
            .csr_err_o        (err[gi]),
`ifdef IBEX_PMP_CSR_LOCK_ALERT_EN
            .pmp_lock_alert_o (alert[gi]),
`endif
            .csr_pmp_cfg_o    (pcfg[gi]),
            .csr_pmp_addr_o   (paddr[gi])
        );
    end

    // Model: legal cfg byte and stored address per granularity and region.
    logic [7:0]  m_cfg  [NG][N];
    logic [31:0] m_addr [NG][N];
    bit          exp_rvalid;
    bit          exp_err;
    logic [31:0] exp_rdata [NG];
    bit          exp_alert [NG];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NG; g++) begin
            for (int i = 0; i < N; i++) begin
                m_cfg[g][i]  = 8'h00;
                m_addr[g][i] = 32'h0;
            end
            exp_rdata[g] = 32'h0;
            exp_alert[g] = 1'b0;
        end
        exp_rvalid = 1'b0;
        exp_err    = 1'b0;
    endtask

    function automatic logic [7:0] legal_cfg(input int g, input logic [7:0] b);
        logic [1:0] mode;
        logic       r, w, x;
        mode = b[4:3];
        if (g >= 1 && mode == 2'd2) mode = 2'd0;
        r = b[0];
        w = b[1] & b[0];
        x = b[2];
        return {b[7], 2'b00, mode, x, w, r};
    endfunction

    function automatic logic [31:0] addr_view(input int g, input logic [7:0] c, input logic [31:0] a);
        int mode;
        mode = int'(c[4:3]);
        if (g >= 2 && mode == 3) return a | ((32'd1 << (g - 1)) - 32'd1);
        if (g >= 1 && mode <= 1) return a & ~((32'd1 << g) - 32'd1);
        return a;
    endfunction

    task automatic model_accept();
        int  i;
        bit  blocked;
        i = int'(idx);
        exp_err = (i >= N);
        for (int g = 0; g < NG; g++) begin
            exp_alert[g] = 1'b0;
            exp_rdata[g] = 32'h0;
            if (i < N) begin
                if (we) begin
                    if (!sel) begin
                        if (m_cfg[g][i][7]) exp_alert[g] = 1'b1;
                        else m_cfg[g][i] = legal_cfg(g, wdata[7:0]);
                    end else begin
                        blocked = m_cfg[g][i][7];
                        if (i + 1 < N) begin
                            if (m_cfg[g][i+1][7] && m_cfg[g][i+1][4:3] == 2'd1) blocked = 1'b1;
                        end
                        if (blocked) exp_alert[g] = 1'b1;
                        else m_addr[g][i] = wdata;
                    end
                end else begin
                    exp_rdata[g] = sel ? addr_view(g, m_cfg[g][i], m_addr[g][i])
                                       : {24'h0, m_cfg[g][i]};
                end
            end
        end
    endtask

    // Drive one cycle of stimulus; returns #1 after the edge with the model updated.
    task automatic issue(input bit r_we, input bit r_sel, input int r_idx,
                         input logic [31:0] r_wd, input bit r_req = 1'b1);
        req   = r_req;
        we    = r_we;
        sel   = r_sel;
        idx   = 4'(r_idx);
        wdata = r_wd;
        @(posedge clk);
        if (!rst && req) begin
            exp_rvalid = 1'b1;
            model_accept();
        end else begin
            exp_rvalid = 1'b0;
            exp_err    = 1'b0;
            for (int g = 0; g < NG; g++) exp_alert[g] = 1'b0;
        end
        #1;
    endtask

    // Every-cycle comparison of all instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < NG; g++) begin
                check($sformatf("g%0d gnt", g), gnt[g], !rst);
                check($sformatf("g%0d rvalid", g), rvalid[g], exp_rvalid);
                if (exp_rvalid) begin
                    check($sformatf("g%0d rdata", g), rdata[g], exp_rdata[g]);
                    check($sformatf("g%0d err", g), err[g], exp_err);
                end
`ifdef IBEX_PMP_CSR_LOCK_ALERT_EN
                check($sformatf("g%0d alert", g), alert[g], exp_alert[g] && exp_rvalid);
`endif
                for (int i = 0; i < N; i++) begin
                    check($sformatf("g%0d cfg_o[%0d]", g, i), pcfg[g][i],
                          {58'd0, m_cfg[g][i][7], m_cfg[g][i][4:3], m_cfg[g][i][2:0]});
                    check($sformatf("g%0d addr_o[%0d]", g, i), paddr[g][i], {m_addr[g][i], 2'b00});
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;

        // Reset readback
        issue(0, 0, 0, 32'h0);
        check("reset rvalid", rvalid[0], 1'b1);
        check("reset rdata", rdata[0], 32'h0);
        check("reset err", err[0], 1'b0);
        check("reset addr_o", paddr[0][0], 34'h0);

        // TOR lock of region 2 freezes addr[1] and addr[2]
        issue(1, 1, 1, 32'h11111111);
        issue(1, 1, 2, 32'h22222222);
        issue(1, 0, 2, 32'h0000008F);
        issue(1, 1, 1, 32'h44444444);
        issue(1, 1, 2, 32'h33333333);
        issue(0, 1, 1, 32'h0);
        check("tor addr1 kept", rdata[0], 32'h11111111);
        issue(0, 1, 2, 32'h0);
        check("locked addr2 kept", rdata[0], 32'h22222222);

        // Locked cfg ignores later writes
        issue(1, 0, 1, 32'h00000097);
        issue(1, 0, 1, 32'h00000000);
`ifdef IBEX_PMP_CSR_LOCK_ALERT_EN
        check("lock alert", alert[0], 1'b1);
`endif
        issue(0, 0, 1, 32'h0);
        check("cfg1 locked G0", rdata[0], 32'h97);
        check("cfg1 locked G1", rdata[1], 32'h87);
        check("cfg1 checker G0", pcfg[0][1], 6'b1_10_111);

        // WARL: W without R, NA4 at G >= 1
        issue(1, 0, 0, 32'h00000002);
        issue(0, 0, 0, 32'h0);
        check("warl w-only", rdata[0], 32'h0);
        issue(1, 0, 0, 32'h00000010);
        issue(0, 0, 0, 32'h0);
        check("na4 G0", rdata[0], 32'h10);
        check("na4 G1", rdata[1], 32'h00);

        // NAPOT read masking at G = 2
        issue(1, 0, 3, 32'h00000018);
        issue(1, 1, 3, 32'h00000000);
        issue(0, 1, 3, 32'h0);
        check("napot G2 read", rdata[2], 32'h1);
        check("napot G2 addr_o", paddr[2][3], 34'h0);

        // Out of range, then back-to-back
        issue(0, 0, 4, 32'h0);
        check("oor err", err[0], 1'b1);
        check("oor rdata", rdata[0], 32'h0);
        issue(1, 1, 5, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            issue(0, 0, k, 32'h0);
            check($sformatf("b2b rvalid %0d", k), rvalid[0], 1'b1);
        end
        issue(0, 0, 0, 32'h0, 1'b0);
        check("idle rvalid", rvalid[0], 1'b0);

        // Reset while a response is showing
        issue(0, 1, 2, 32'h0);
        rst = 1'b1;
        model_reset();
        #1;
        check("mid-reset rvalid", rvalid[0], 1'b0);
        check("mid-reset gnt", gnt[0], 1'b0);
        issue(0, 0, 1, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        check("lock cleared", pcfg[0][1], 6'd0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            bit          r_we, r_sel, r_req;
            int          r_idx;
            logic [31:0] r_wd;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset();
                @(negedge clk);
                #2 rst = 1'b0;
            end
            r_we  = 1'($urandom_range(0, 1));
            r_sel = 1'($urandom_range(0, 1));
            r_req = ($urandom_range(0, 9) != 0);
            r_idx = int'($urandom_range(0, 4));
            r_wd  = $urandom;
            if (!r_sel && $urandom_range(0, 7) != 0) r_wd[7] = 1'b0;
            issue(r_we, r_sel, r_idx, r_wd, r_req);
        end

        issue(0, 0, 0, 32'h0, 1'b0);
        @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
